// File: rtl/axi4_lite_arbiter_2to1.sv
// ---------------------------------------------------------------------------
// axi4_lite_arbiter_2to1
//
// Two AXI4-Lite requesters (s0, s1) share one downstream AXI4-Lite port (m).
// Write and read paths have independent three-state FSMs and independent
// round-robin grant state, so a write from one requester and a read from the
// other can be in flight at the same time.
//
// Ports:
//   aclk, areset        clock and asynchronous active-high reset
//   s0_axi_*, s1_axi_*  slave-side AXI4-Lite channels (AW, W, B, AR, R)
//   m_axi_*             master-side AXI4-Lite channels to the register block
//
// Payloads are muxed combinationally from the granted requester. Downstream
// responses (bresp, rdata, rresp) are broadcast; only the granted requester
// sees the matching bvalid/rvalid.
// ---------------------------------------------------------------------------
module axi4_lite_arbiter_2to1 #(
    parameter int unsigned AXI_ALEN = 64,
    parameter int unsigned AXI_DLEN = 64,
    parameter int unsigned AXI_SLEN = AXI_DLEN / 8
) (
    input  logic                aclk,
    input  logic                areset,

    // Requester 0
    input  logic [AXI_ALEN-1:0] s0_axi_awaddr_i,
    input  logic [2:0]          s0_axi_awprot_i,
    input  logic                s0_axi_awvalid_i,
    output logic                s0_axi_awready_o,
    input  logic [AXI_DLEN-1:0] s0_axi_wdata_i,
    input  logic [AXI_SLEN-1:0] s0_axi_wstrb_i,
    input  logic                s0_axi_wvalid_i,
    output logic                s0_axi_wready_o,
    output logic [1:0]          s0_axi_bresp_o,
    output logic                s0_axi_bvalid_o,
    input  logic                s0_axi_bready_i,
    input  logic [AXI_ALEN-1:0] s0_axi_araddr_i,
    input  logic [2:0]          s0_axi_arprot_i,
    input  logic                s0_axi_arvalid_i,
    output logic                s0_axi_arready_o,
    output logic [AXI_DLEN-1:0] s0_axi_rdata_o,
    output logic [1:0]          s0_axi_rresp_o,
    output logic                s0_axi_rvalid_o,
    input  logic                s0_axi_rready_i,

    // Requester 1
    input  logic [AXI_ALEN-1:0] s1_axi_awaddr_i,
    input  logic [2:0]          s1_axi_awprot_i,
    input  logic                s1_axi_awvalid_i,
    output logic                s1_axi_awready_o,
    input  logic [AXI_DLEN-1:0] s1_axi_wdata_i,
    input  logic [AXI_SLEN-1:0] s1_axi_wstrb_i,
    input  logic                s1_axi_wvalid_i,
    output logic                s1_axi_wready_o,
    output logic [1:0]          s1_axi_bresp_o,
    output logic                s1_axi_bvalid_o,
    input  logic                s1_axi_bready_i,
    input  logic [AXI_ALEN-1:0] s1_axi_araddr_i,
    input  logic [2:0]          s1_axi_arprot_i,
    input  logic                s1_axi_arvalid_i,
    output logic                s1_axi_arready_o,
    output logic [AXI_DLEN-1:0] s1_axi_rdata_o,
    output logic [1:0]          s1_axi_rresp_o,
    output logic                s1_axi_rvalid_o,
    input  logic                s1_axi_rready_i,

    // Shared downstream port
    output logic [AXI_ALEN-1:0] m_axi_awaddr_o,
    output logic [2:0]          m_axi_awprot_o,
    output logic                m_axi_awvalid_o,
    input  logic                m_axi_awready_i,
    output logic [AXI_DLEN-1:0] m_axi_wdata_o,
    output logic [AXI_SLEN-1:0] m_axi_wstrb_o,
    output logic                m_axi_wvalid_o,
    input  logic                m_axi_wready_i,
    input  logic [1:0]          m_axi_bresp_i,
    input  logic                m_axi_bvalid_i,
    output logic                m_axi_bready_o,
    output logic [AXI_ALEN-1:0] m_axi_araddr_o,
    output logic [2:0]          m_axi_arprot_o,
    output logic                m_axi_arvalid_o,
    input  logic                m_axi_arready_i,
    input  logic [AXI_DLEN-1:0] m_axi_rdata_i,
    input  logic [1:0]          m_axi_rresp_i,
    input  logic                m_axi_rvalid_i,
    output logic                m_axi_rready_o
);

    typedef enum logic [1:0] {WIdle, WAddr, WResp} wstate_e;
    typedef enum logic [1:0] {RIdle, RAddr, RData} rstate_e;

    wstate_e wstate_q;
    rstate_e rstate_q;
    logic    wgnt_q, wlast_q, aw_done_q, w_done_q;
    logic    rgnt_q, rlast_q;

    // Round-robin pick: a lone requester wins; under contention the index
    // that did not complete last wins.
    function automatic logic pick(input logic req0, input logic req1, input logic last);
        if (req0 && req1) begin
            return ~last;
        end
        return req1;
    endfunction

    logic w_addr, w_resp, r_addr, r_data;
    logic g_awvalid, g_wvalid, g_bready, g_arvalid, g_rready;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic aw_rdy, w_rdy, b_vld, ar_rdy, r_vld;

    assign w_addr = (wstate_q == WAddr);
    assign w_resp = (wstate_q == WResp);
    assign r_addr = (rstate_q == RAddr);
    assign r_data = (rstate_q == RData);

    assign g_awvalid = wgnt_q ? s1_axi_awvalid_i : s0_axi_awvalid_i;
    assign g_wvalid  = wgnt_q ? s1_axi_wvalid_i  : s0_axi_wvalid_i;
    assign g_bready  = wgnt_q ? s1_axi_bready_i  : s0_axi_bready_i;
    assign g_arvalid = rgnt_q ? s1_axi_arvalid_i : s0_axi_arvalid_i;
    assign g_rready  = rgnt_q ? s1_axi_rready_i  : s0_axi_rready_i;

    // Payload muxes
    assign m_axi_awaddr_o = wgnt_q ? s1_axi_awaddr_i : s0_axi_awaddr_i;
    assign m_axi_awprot_o = wgnt_q ? s1_axi_awprot_i : s0_axi_awprot_i;
    assign m_axi_wdata_o  = wgnt_q ? s1_axi_wdata_i  : s0_axi_wdata_i;
    assign m_axi_wstrb_o  = wgnt_q ? s1_axi_wstrb_i  : s0_axi_wstrb_i;
    assign m_axi_araddr_o = rgnt_q ? s1_axi_araddr_i : s0_axi_araddr_i;
    assign m_axi_arprot_o = rgnt_q ? s1_axi_arprot_i : s0_axi_arprot_i;

    // Downstream valids/readies exist only in the owning state; done flags
    // stop a channel from being presented twice while the other catches up.
    assign m_axi_awvalid_o = w_addr & g_awvalid & ~aw_done_q;
    assign m_axi_wvalid_o  = w_addr & g_wvalid & ~w_done_q;
    assign m_axi_bready_o  = w_resp & g_bready;
    assign m_axi_arvalid_o = r_addr & g_arvalid;
    assign m_axi_rready_o  = r_data & g_rready;

    assign aw_hs = m_axi_awvalid_o & m_axi_awready_i;
    assign w_hs  = m_axi_wvalid_o & m_axi_wready_i;
    assign b_hs  = m_axi_bready_o & m_axi_bvalid_i;
    assign ar_hs = m_axi_arvalid_o & m_axi_arready_i;
    assign r_hs  = m_axi_rready_o & m_axi_rvalid_i;

    // Upstream readies depend on state only, never on the requester's own
    // valid, so IDLE carries no valid-to-ready path.
    assign aw_rdy = w_addr & m_axi_awready_i & ~aw_done_q;
    assign w_rdy  = w_addr & m_axi_wready_i & ~w_done_q;
    assign b_vld  = w_resp & m_axi_bvalid_i;
    assign ar_rdy = r_addr & m_axi_arready_i;
    assign r_vld  = r_data & m_axi_rvalid_i;

    assign s0_axi_awready_o = aw_rdy & ~wgnt_q;
    assign s1_axi_awready_o = aw_rdy & wgnt_q;
    assign s0_axi_wready_o  = w_rdy & ~wgnt_q;
    assign s1_axi_wready_o  = w_rdy & wgnt_q;
    assign s0_axi_bvalid_o  = b_vld & ~wgnt_q;
    assign s1_axi_bvalid_o  = b_vld & wgnt_q;
    assign s0_axi_arready_o = ar_rdy & ~rgnt_q;
    assign s1_axi_arready_o = ar_rdy & rgnt_q;
    assign s0_axi_rvalid_o  = r_vld & ~rgnt_q;
    assign s1_axi_rvalid_o  = r_vld & rgnt_q;

    assign s0_axi_bresp_o = m_axi_bresp_i;
    assign s1_axi_bresp_o = m_axi_bresp_i;
    assign s0_axi_rdata_o = m_axi_rdata_i;
    assign s1_axi_rdata_o = m_axi_rdata_i;
    assign s0_axi_rresp_o = m_axi_rresp_i;
    assign s1_axi_rresp_o = m_axi_rresp_i;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wstate_q  <= WIdle;
            wgnt_q    <= 1'b0;
            wlast_q   <= 1'b1;  // s0 wins the first contention
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rstate_q  <= RIdle;
            rgnt_q    <= 1'b0;
            rlast_q   <= 1'b1;
        end else begin
            unique case (wstate_q)
                WIdle: begin
                    if (s0_axi_awvalid_i || s1_axi_awvalid_i) begin
                        wgnt_q   <= pick(s0_axi_awvalid_i, s1_axi_awvalid_i, wlast_q);
                        wstate_q <= WAddr;
                    end
                end
                WAddr: begin
                    if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        wstate_q  <= WResp;
                    end else begin
                        aw_done_q <= aw_done_q | aw_hs;
                        w_done_q  <= w_done_q | w_hs;
                    end
                end
                WResp: begin
                    if (b_hs) begin
                        wlast_q  <= wgnt_q;
                        wstate_q <= WIdle;
                    end
                end
                default: wstate_q <= WIdle;
            endcase

            unique case (rstate_q)
                RIdle: begin
                    if (s0_axi_arvalid_i || s1_axi_arvalid_i) begin
                        rgnt_q   <= pick(s0_axi_arvalid_i, s1_axi_arvalid_i, rlast_q);
                        rstate_q <= RAddr;
                    end
                end
                RAddr: begin
                    if (ar_hs) begin
                        rstate_q <= RData;
                    end
                end
                RData: begin
                    if (r_hs) begin
                        rlast_q  <= rgnt_q;
                        rstate_q <= RIdle;
                    end
                end
                default: rstate_q <= RIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_arbiter_2to1.sv
// ---------------------------------------------------------------------------
// Bench for axi4_lite_arbiter_2to1. Directed requester stimulus pushes
// expected downstream addresses/data and upstream responses into queues; a
// monitor pops and compares on every observed handshake. A small downstream
// slave model answers writes and reads.
// ---------------------------------------------------------------------------
module tb_axi4_lite_arbiter_2to1;

    localparam int AL = 64;
    localparam int DL = 64;
    localparam int SL = 8;

    logic aclk = 1'b0;
    logic areset;
    always #5 aclk = ~aclk;

    // Requester-side signals, index = requester
    logic [AL-1:0] s_awaddr [2];
    logic [2:0]    s_awprot [2];
    logic [1:0]    s_awvalid, s_awready;
    logic [DL-1:0] s_wdata [2];
    logic [SL-1:0] s_wstrb [2];
    logic [1:0]    s_wvalid, s_wready;
    logic [1:0]    s_bresp [2];
    logic [1:0]    s_bvalid, s_bready;
    logic [AL-1:0] s_araddr [2];
    logic [2:0]    s_arprot [2];
    logic [1:0]    s_arvalid, s_arready;
    logic [DL-1:0] s_rdata [2];
    logic [1:0]    s_rresp [2];
    logic [1:0]    s_rvalid, s_rready;

    // Downstream side
    logic [AL-1:0] m_awaddr;
    logic [2:0]    m_awprot;
    logic          m_awvalid, m_awready;
    logic [DL-1:0] m_wdata;
    logic [SL-1:0] m_wstrb;
    logic          m_wvalid, m_wready;
    logic [1:0]    m_bresp;
    logic          m_bvalid, m_bready;
    logic [AL-1:0] m_araddr;
    logic [2:0]    m_arprot;
    logic          m_arvalid, m_arready;
    logic [DL-1:0] m_rdata;
    logic [1:0]    m_rresp;
    logic          m_rvalid, m_rready;

    axi4_lite_arbiter_2to1 #(
        .AXI_ALEN(AL),
        .AXI_DLEN(DL),
        .AXI_SLEN(SL)
    ) dut (
        .aclk             (aclk),
        .areset           (areset),
        .s0_axi_awaddr_i  (s_awaddr[0]),
        .s0_axi_awprot_i  (s_awprot[0]),
        .s0_axi_awvalid_i (s_awvalid[0]),
        .s0_axi_awready_o (s_awready[0]),
        .s0_axi_wdata_i   (s_wdata[0]),
        .s0_axi_wstrb_i   (s_wstrb[0]),
        .s0_axi_wvalid_i  (s_wvalid[0]),
        .s0_axi_wready_o  (s_wready[0]),
        .s0_axi_bresp_o   (s_bresp[0]),
        .s0_axi_bvalid_o  (s_bvalid[0]),
        .s0_axi_bready_i  (s_bready[0]),
        .s0_axi_araddr_i  (s_araddr[0]),
        .s0_axi_arprot_i  (s_arprot[0]),
        .s0_axi_arvalid_i (s_arvalid[0]),
        .s0_axi_arready_o (s_arready[0]),
        .s0_axi_rdata_o   (s_rdata[0]),
        .s0_axi_rresp_o   (s_rresp[0]),
        .s0_axi_rvalid_o  (s_rvalid[0]),
        .s0_axi_rready_i  (s_rready[0]),
        .s1_axi_awaddr_i  (s_awaddr[1]),
        .s1_axi_awprot_i  (s_awprot[1]),
        .s1_axi_awvalid_i (s_awvalid[1]),
        .s1_axi_awready_o (s_awready[1]),
        .s1_axi_wdata_i   (s_wdata[1]),
        .s1_axi_wstrb_i   (s_wstrb[1]),
        .s1_axi_wvalid_i  (s_wvalid[1]),
        .s1_axi_wready_o  (s_wready[1]),
        .s1_axi_bresp_o   (s_bresp[1]),
        .s1_axi_bvalid_o  (s_bvalid[1]),
        .s1_axi_bready_i  (s_bready[1]),
        .s1_axi_araddr_i  (s_araddr[1]),
        .s1_axi_arprot_i  (s_arprot[1]),
        .s1_axi_arvalid_i (s_arvalid[1]),
        .s1_axi_arready_o (s_arready[1]),
        .s1_axi_rdata_o   (s_rdata[1]),
        .s1_axi_rresp_o   (s_rresp[1]),
        .s1_axi_rvalid_o  (s_rvalid[1]),
        .s1_axi_rready_i  (s_rready[1]),
        .m_axi_awaddr_o   (m_awaddr),
        .m_axi_awprot_o   (m_awprot),
        .m_axi_awvalid_o  (m_awvalid),
        .m_axi_awready_i  (m_awready),
        .m_axi_wdata_o    (m_wdata),
        .m_axi_wstrb_o    (m_wstrb),
        .m_axi_wvalid_o   (m_wvalid),
        .m_axi_wready_i   (m_wready),
        .m_axi_bresp_i    (m_bresp),
        .m_axi_bvalid_i   (m_bvalid),
        .m_axi_bready_o   (m_bready),
        .m_axi_araddr_o   (m_araddr),
        .m_axi_arprot_o   (m_arprot),
        .m_axi_arvalid_o  (m_arvalid),
        .m_axi_arready_i  (m_arready),
        .m_axi_rdata_i    (m_rdata),
        .m_axi_rresp_i    (m_rresp),
        .m_axi_rvalid_i   (m_rvalid),
        .m_axi_rready_o   (m_rready)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard queues
    logic [63:0] exp_maw[$], exp_mw[$], exp_mar[$], exp_r0[$], exp_r1[$];
    logic [7:0]  exp_mws[$];
    logic [1:0]  exp_b0[$], exp_b1[$];

    // Monitor-owned observations
    int cyc = 0;
    int s1_any_cnt = 0, s1_awrdy_cnt = 0, s1_wrdy_cnt = 0, m_wvalid_cnt = 0;
    int last_b0_cyc = 0, last_s1_aw_cyc = 0;
    logic hs_aw = 0, hs_w = 0, hs_b = 0, hs_ar = 0, hs_r = 0;

    // Stimulus-owned slave knobs
    logic          aw_stall = 1'b0;
    int            b_delay = 0;
    logic [DL-1:0] slave_rdata = '0;

    // Monitor: sampled mid-cycle, so a handshake seen here completes at the
    // next rising edge.
    initial begin
        logic [63:0] e;
        logic [7:0]  es;
        logic [1:0]  eb;
        forever begin
            @(negedge aclk);
            cyc++;
            hs_aw = m_awvalid & m_awready;
            hs_w  = m_wvalid & m_wready;
            hs_b  = m_bvalid & m_bready;
            hs_ar = m_arvalid & m_arready;
            hs_r  = m_rvalid & m_rready;
            if (hs_aw) begin
                if (exp_maw.size() == 0) check("m_aw_unexpected", 64'(exp_maw.size()), 64'd1);
                else begin e = exp_maw.pop_front(); check("m_awaddr", m_awaddr, e); end
            end
            if (hs_w) begin
                if (exp_mw.size() == 0) check("m_w_unexpected", 64'(exp_mw.size()), 64'd1);
                else begin
                    e  = exp_mw.pop_front();
                    es = exp_mws.pop_front();
                    check("m_wdata", m_wdata, e);
                    check("m_wstrb", 64'(m_wstrb), 64'(es));
                end
            end
            if (hs_ar) begin
                if (exp_mar.size() == 0) check("m_ar_unexpected", 64'(exp_mar.size()), 64'd1);
                else begin e = exp_mar.pop_front(); check("m_araddr", m_araddr, e); end
            end
            if (s_bvalid[0] && s_bready[0]) begin
                last_b0_cyc = cyc;
                if (exp_b0.size() == 0) check("s0_b_unexpected", 64'(exp_b0.size()), 64'd1);
                else begin eb = exp_b0.pop_front(); check("s0_bresp", 64'(s_bresp[0]), 64'(eb)); end
            end
            if (s_bvalid[1] && s_bready[1]) begin
                if (exp_b1.size() == 0) check("s1_b_unexpected", 64'(exp_b1.size()), 64'd1);
                else begin eb = exp_b1.pop_front(); check("s1_bresp", 64'(s_bresp[1]), 64'(eb)); end
            end
            if (s_rvalid[0] && s_rready[0]) begin
                if (exp_r0.size() == 0) check("s0_r_unexpected", 64'(exp_r0.size()), 64'd1);
                else begin e = exp_r0.pop_front(); check("s0_rdata", s_rdata[0], e); end
            end
            if (s_rvalid[1] && s_rready[1]) begin
                if (exp_r1.size() == 0) check("s1_r_unexpected", 64'(exp_r1.size()), 64'd1);
                else begin e = exp_r1.pop_front(); check("s1_rdata", s_rdata[1], e); end
            end
            if (s_awvalid[1] && s_awready[1]) last_s1_aw_cyc = cyc;
            if (s_awready[1] | s_wready[1] | s_arready[1] | s_bvalid[1] | s_rvalid[1]) s1_any_cnt++;
            if (s_awready[1]) s1_awrdy_cnt++;
            if (s_wready[1]) s1_wrdy_cnt++;
            if (m_wvalid) m_wvalid_cnt++;
        end
    end

    // Downstream slave model
    initial begin
        int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0, b_wait = 0;
        m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
        m_bvalid = 1'b0; m_bresp = 2'b00; m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00;
        forever begin
            @(posedge aclk); #1;
            m_awready = !aw_stall;
            if (areset) begin
                m_bvalid = 1'b0; m_rvalid = 1'b0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0; b_wait = 0;
            end else begin
                if (hs_aw) aw_cnt++;
                if (hs_w) w_cnt++;
                if (hs_ar) ar_cnt++;
                if (hs_b) begin m_bvalid = 1'b0; b_cnt++; b_wait = 0; end
                if (hs_r) begin m_rvalid = 1'b0; r_cnt++; end
                if (!m_bvalid && b_cnt < ((aw_cnt < w_cnt) ? aw_cnt : w_cnt)) begin
                    if (b_wait >= b_delay) begin m_bvalid = 1'b1; m_bresp = 2'b00; end
                    else b_wait++;
                end
                if (!m_rvalid && r_cnt < ar_cnt) begin m_rvalid = 1'b1; m_rdata = slave_rdata; end
            end
        end
    end

    // Called at posedge+#1. Drops AW/W after their handshakes, then optionally
    // waits for B (bready held high by the bench).
    task automatic do_write(input int idx, input logic [63:0] addr, input logic [63:0] data,
                            input logic [7:0] strb, input int w_lead, input bit wait_b);
        int g;
        bit awf, wf;
        if (wait_b) begin
            if (idx == 0) exp_b0.push_back(2'b00); else exp_b1.push_back(2'b00);
        end
        s_awaddr[idx] = addr;
        s_awprot[idx] = 3'(idx);
        s_wdata[idx]  = data;
        s_wstrb[idx]  = strb;
        s_wvalid[idx] = 1'b1;
        repeat (w_lead) begin @(posedge aclk); #1; end
        s_awvalid[idx] = 1'b1;
        g = 0;
        while ((s_awvalid[idx] || s_wvalid[idx]) && g < 200) begin
            @(negedge aclk);
            awf = s_awvalid[idx] & s_awready[idx];
            wf  = s_wvalid[idx] & s_wready[idx];
            @(posedge aclk); #1;
            if (awf) s_awvalid[idx] = 1'b0;
            if (wf) s_wvalid[idx] = 1'b0;
            g++;
        end
        check("wr_aw_w_accepted", 64'({s_awvalid[idx], s_wvalid[idx]}), 64'd0);
        if (wait_b) begin
            g = 0;
            @(negedge aclk);
            while (!s_bvalid[idx] && g < 200) begin @(negedge aclk); g++; end
            check("wr_b_seen", 64'(s_bvalid[idx]), 64'd1);
            @(posedge aclk); #1;
        end
    endtask

    task automatic do_read(input int idx, input logic [63:0] addr, input logic [63:0] exp);
        int g;
        bit arf;
        if (idx == 0) exp_r0.push_back(exp); else exp_r1.push_back(exp);
        s_araddr[idx]  = addr;
        s_arprot[idx]  = 3'(idx);
        s_arvalid[idx] = 1'b1;
        g = 0;
        while (s_arvalid[idx] && g < 200) begin
            @(negedge aclk);
            arf = s_arvalid[idx] & s_arready[idx];
            @(posedge aclk); #1;
            if (arf) s_arvalid[idx] = 1'b0;
            g++;
        end
        check("rd_ar_accepted", 64'(s_arvalid[idx]), 64'd0);
        g = 0;
        @(negedge aclk);
        while (!s_rvalid[idx] && g < 200) begin @(negedge aclk); g++; end
        check("rd_r_seen", 64'(s_rvalid[idx]), 64'd1);
        @(posedge aclk); #1;
    endtask

    function automatic logic [63:0] all_vr();
        return 64'({s_awready, s_wready, s_bvalid, s_arready, s_rvalid,
                    m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready});
    endfunction

    task automatic pulse_reset();
        areset = 1'b1;
        @(negedge aclk);
        check("reset_valid_ready_zero", all_vr(), 64'd0);
        @(posedge aclk); #1;
        areset = 1'b0;
        @(posedge aclk); #1;
    endtask

    initial begin
        int snap, snap2, snap3, g;
        areset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_awaddr[i] = '0; s_awprot[i] = '0; s_wdata[i] = '0; s_wstrb[i] = '0;
            s_araddr[i] = '0; s_arprot[i] = '0;
        end
        s_awvalid = '0; s_wvalid = '0; s_arvalid = '0;
        s_bready = 2'b11; s_rready = 2'b11;

        // Reset state
        @(negedge aclk);
        check("por_valid_ready_zero", all_vr(), 64'd0);
        @(posedge aclk); #1;
        areset = 1'b0;
        @(posedge aclk); #1;

        // Single s0 write; s1 must see nothing
        snap = s1_any_cnt;
        exp_maw.push_back(64'h8); exp_mw.push_back(64'hA5); exp_mws.push_back(8'hFF);
        do_write(0, 64'h8, 64'hA5, 8'hFF, 0, 1'b1);
        check("s1_quiet_during_s0", 64'(s1_any_cnt - snap), 64'd0);

        // Contention from reset: s0 then s1, twice
        pulse_reset();
        exp_maw.push_back(64'h10); exp_mw.push_back(64'h11); exp_mws.push_back(8'hFF);
        exp_maw.push_back(64'h20); exp_mw.push_back(64'h22); exp_mws.push_back(8'h0F);
        fork
            do_write(0, 64'h10, 64'h11, 8'hFF, 0, 1'b1);
            do_write(1, 64'h20, 64'h22, 8'h0F, 0, 1'b1);
        join
        exp_maw.push_back(64'h30); exp_mw.push_back(64'h33); exp_mws.push_back(8'hFF);
        exp_maw.push_back(64'h40); exp_mw.push_back(64'h44); exp_mws.push_back(8'h0F);
        fork
            do_write(0, 64'h30, 64'h33, 8'hFF, 0, 1'b1);
            do_write(1, 64'h40, 64'h44, 8'h0F, 0, 1'b1);
        join

        // s1 W leads AW by 3 cycles; downstream AW stalled so W lands first
        aw_stall = 1'b1;
        snap = m_wvalid_cnt;
        exp_maw.push_back(64'h28); exp_mw.push_back(64'h99); exp_mws.push_back(8'h0F);
        fork
            do_write(1, 64'h28, 64'h99, 8'h0F, 3, 1'b1);
            begin
                repeat (3) @(posedge aclk);
                check("w_lead_no_m_wvalid", 64'(m_wvalid_cnt - snap), 64'd0);
                repeat (3) @(posedge aclk);
                #1 aw_stall = 1'b0;
            end
        join
        check("w_lead_single_w", 64'(m_wvalid_cnt - snap), 64'd1);

        // Concurrent s0 write and s1 read
        slave_rdata = 64'h3C;
        exp_maw.push_back(64'h18); exp_mw.push_back(64'h5A); exp_mws.push_back(8'hFF);
        exp_mar.push_back(64'h0);
        fork
            do_write(0, 64'h18, 64'h5A, 8'hFF, 0, 1'b1);
            do_read(1, 64'h0, 64'h3C);
        join

        // Reset while waiting for bready; the B must never complete
        s_bready[0] = 1'b0;
        exp_maw.push_back(64'h48); exp_mw.push_back(64'h4A); exp_mws.push_back(8'hFF);
        do_write(0, 64'h48, 64'h4A, 8'hFF, 0, 1'b0);
        g = 0;
        @(negedge aclk);
        while (!s_bvalid[0] && g < 50) begin @(negedge aclk); g++; end
        check("wresp_pending_before_reset", 64'(s_bvalid[0]), 64'd1);
        @(posedge aclk); #1;
        areset = 1'b1;
        @(negedge aclk);
        check("midtxn_reset_zero", all_vr(), 64'd0);
        @(posedge aclk); #1;
        areset = 1'b0;
        s_bready[0] = 1'b1;
        @(posedge aclk); #1;
        // Last completed write was s0, so only the reset makes s0 win here
        exp_maw.push_back(64'h50); exp_mw.push_back(64'h55); exp_mws.push_back(8'hFF);
        exp_maw.push_back(64'h60); exp_mw.push_back(64'h66); exp_mws.push_back(8'h0F);
        fork
            do_write(0, 64'h50, 64'h55, 8'hFF, 0, 1'b1);
            do_write(1, 64'h60, 64'h66, 8'h0F, 0, 1'b1);
        join

        // Read contention after reset: s0 first, then s1
        slave_rdata = 64'hC3;
        exp_mar.push_back(64'h100); exp_mar.push_back(64'h200);
        fork
            do_read(0, 64'h100, 64'hC3);
            do_read(1, 64'h200, 64'hC3);
        join

        // Long B stall with s1 waiting
        b_delay = 10;
        snap2 = s1_awrdy_cnt;
        snap3 = s1_wrdy_cnt;
        exp_maw.push_back(64'h70); exp_mw.push_back(64'h77); exp_mws.push_back(8'hFF);
        exp_maw.push_back(64'h80); exp_mw.push_back(64'h88); exp_mws.push_back(8'h0F);
        fork
            do_write(0, 64'h70, 64'h77, 8'hFF, 0, 1'b1);
            begin
                repeat (5) begin @(posedge aclk); #1; end
                do_write(1, 64'h80, 64'h88, 8'h0F, 0, 1'b1);
            end
        join
        b_delay = 0;
        check("stall_s1_awready_once", 64'(s1_awrdy_cnt - snap2), 64'd1);
        check("stall_s1_wready_once", 64'(s1_wrdy_cnt - snap3), 64'd1);
        check("stall_one_idle_gap", 64'(last_s1_aw_cyc - last_b0_cyc), 64'd2);

        repeat (4) @(posedge aclk);
        check("q_maw_empty", 64'(exp_maw.size()), 64'd0);
        check("q_mw_empty", 64'(exp_mw.size()), 64'd0);
        check("q_mar_empty", 64'(exp_mar.size()), 64'd0);
        check("q_b0_empty", 64'(exp_b0.size()), 64'd0);
        check("q_b1_empty", 64'(exp_b1.size()), 64'd0);
        check("q_r0_empty", 64'(exp_r0.size()), 64'd0);
        check("q_r1_empty", 64'(exp_r1.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
